bcd_seq_conv: RTL and testbench

Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It replaces the combinational converter on wide paths where a W-deep adder chain breaks timing. It sits between the UART TX formatter and the binary data sources. Uses a start/valid handshake, a configurable digit count with overflow detection, and optional signed input.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_seq_conv_if.sv | 15 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bcd_seq_conv.sv | 88 ++++++++
 tb/tb_bcd_seq_conv.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and digit-count helper for the BCD converter.
package bcd_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD = 4'd3;
  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;
  // decimal digits of 2^w-1 is floor(w*log10(2))+1; 2^w is never a power of ten
  function automatic int min_digits(input int w);
    return (w * 30103) / 100000 + 1;
  endfunction
endpackage

// File: rtl/bcd_seq_conv_if.sv
// bcd_seq_conv_if: start/valid handshake and result bundle of the sequential BCD converter.
interface bcd_seq_conv_if #(
  parameter int W = 18,
  parameter int DIGITS = 6
);
  logic start;
  logic [W-1:0] bin;
  logic ready;
  logic valid;
  logic [4*DIGITS-1:0] bcd;
  logic overflow;
  logic sign;
  modport master(output start, bin, input ready, valid, bcd, overflow, sign);
  modport slave(input start, bin, output ready, valid, bcd, overflow, sign);
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to a BCD digit of 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  always_comb o_d = (i_d >= ADJ_THRESH) ? i_d + ADJ_ADD : i_d;
endmodule

// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential binary-to-BCD (double dabble), one bit per clock, sticky overflow.
// Define BCD_SIGNED_EN to treat bin as two's complement and report the sign.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int W = 18,
  parameter int DIGITS = 6
) (
  input logic clk,
  input logic rst,
  bcd_seq_conv_if.slave bus
);
  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(W + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_sh, w_load;
  logic [BW-1:0] r_dig, w_adj, r_bcd, w_dig_next;
  logic r_ovf, r_ovf_out, r_sign_out, w_last, w_ovf_next;
`ifdef BCD_SIGNED_EN
  logic r_sign;
`endif
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_d(r_dig[BCD_DIGIT_W*d +: BCD_DIGIT_W]),
      .o_d(w_adj[BCD_DIGIT_W*d +: BCD_DIGIT_W])
    );
  end
  always_comb begin
`ifdef BCD_SIGNED_EN
    w_load = bus.bin[W-1] ? W'(-bus.bin) : bus.bin;
`else
    w_load = bus.bin;
`endif
    w_last = r_cnt == CW'(1);
    w_dig_next = {w_adj[BW-2:0], r_sh[W-1]};
    // the bit leaving the top digit is a lost decimal carry
    w_ovf_next = r_ovf | w_adj[BW-1];
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = bus.start ? S_SHIFT : S_IDLE;
      S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
      default: w_next = S_IDLE;
    endcase
    bus.ready = r_state == S_IDLE;
    bus.valid = r_state == S_DONE;
    bus.bcd = r_bcd;
    bus.overflow = r_ovf_out;
    bus.sign = r_sign_out;
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sh <= '0;
      r_dig <= '0;
      r_ovf <= 1'b0;
      r_bcd <= '0;
      r_ovf_out <= 1'b0;
      r_sign_out <= 1'b0;
`ifdef BCD_SIGNED_EN
      r_sign <= 1'b0;
`endif
    end else if (r_state == S_IDLE && bus.start) begin
      r_sh <= w_load;
      r_dig <= '0;
      r_ovf <= 1'b0;
      r_cnt <= CW'(W);
`ifdef BCD_SIGNED_EN
      r_sign <= bus.bin[W-1];
`endif
    end else if (r_state == S_SHIFT) begin
      r_dig <= w_dig_next;
      r_sh <= r_sh << 1;
      r_ovf <= w_ovf_next;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_bcd <= w_dig_next;
        r_ovf_out <= w_ovf_next;
`ifdef BCD_SIGNED_EN
        r_sign_out <= r_sign;
`else
        r_sign_out <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb_bcd_seq_conv: directed scoreboard bench for bcd_seq_conv (6-digit and 4-digit instances).
module tb_bcd_seq_conv;
  typedef struct {
    logic [23:0] bcd;
    logic ovf;
    logic sgn;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int nva = 0, vca = 0, nvb = 0, vcb = 0, tl_a = 0, tl_b = 0, n0 = 0, pv = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  bcd_seq_conv_if #(.W(18), .DIGITS(6)) a ();
  bcd_seq_conv_if #(.W(18), .DIGITS(4)) b ();
  bcd_seq_conv #(.W(18), .DIGITS(6)) u_a (.clk(clk), .rst(rst), .bus(a));
  bcd_seq_conv #(.W(18), .DIGITS(4)) u_b (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [17:0] v, input int digits);
    exp_t r;
    int unsigned mag, lim;
    mag = 32'(v);
    r.sgn = 1'b0;
`ifdef BCD_SIGNED_EN
    if (v[17]) begin
      mag = 32'd262144 - mag;
      r.sgn = 1'b1;
    end
`endif
    lim = 1;
    for (int i = 0; i < digits; i++) lim *= 10;
    r.ovf = mag >= lim;
    mag = mag % lim;
    r.bcd = '0;
    for (int i = 0; i < digits; i++) begin
      r.bcd[4*i +: 4] = 4'(mag % 10);
      mag /= 10;
    end
    return r;
  endfunction
  always @(negedge clk) if (a.valid === 1'b1) begin
    nva++;
    vca = cyc;
    chk("valid_a_expected", 32'(qa.size() != 0), 1);
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      chk("bcd_a", 32'(a.bcd), 32'(ea.bcd));
      chk("ovf_a", 32'(a.overflow), 32'(ea.ovf));
      chk("sign_a", 32'(a.sign), 32'(ea.sgn));
    end
  end
  always @(negedge clk) if (b.valid === 1'b1) begin
    nvb++;
    vcb = cyc;
    chk("valid_b_expected", 32'(qb.size() != 0), 1);
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      chk("bcd_b", 32'(b.bcd), 32'(eb.bcd));
      chk("ovf_b", 32'(b.overflow), 32'(eb.ovf));
      chk("sign_b", 32'(b.sign), 32'(eb.sgn));
    end
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic launch_a(input logic [17:0] v);
    for (int i = 0; i < 60 && a.ready !== 1'b1; i++) step();
    chk("ready_before_start_a", 32'(a.ready), 1);
    a.start = 1'b1;
    a.bin = v;
    tl_a = cyc;
    qa.push_back(model(v, 6));
    step();
    a.start = 1'b0;
    a.bin = 18'($urandom);
  endtask
  task automatic wait_a();
    int s = nva;
    for (int i = 0; i < 40 && nva == s; i++) step();
    chk("valid_count_a", 32'(nva - s), 1);
    chk("latency_a", 32'(vca - tl_a), 19);
    step();
    chk("ready_after_a", 32'(a.ready), 1);
    chk("valid_pulse_a", 32'(a.valid), 0);
  endtask
  task automatic launch_b(input logic [17:0] v);
    for (int i = 0; i < 60 && b.ready !== 1'b1; i++) step();
    chk("ready_before_start_b", 32'(b.ready), 1);
    b.start = 1'b1;
    b.bin = v;
    tl_b = cyc;
    qb.push_back(model(v, 4));
    step();
    b.start = 1'b0;
    b.bin = 18'($urandom);
  endtask
  task automatic wait_b();
    int s = nvb;
    for (int i = 0; i < 40 && nvb == s; i++) step();
    chk("valid_count_b", 32'(nvb - s), 1);
    chk("latency_b", 32'(vcb - tl_b), 19);
    step();
    chk("ready_after_b", 32'(b.ready), 1);
  endtask
  initial begin
    a.start = 1'b0;
    a.bin = '0;
    b.start = 1'b0;
    b.bin = '0;
    repeat (3) step();
    chk("rst_ready", 32'(a.ready), 1);
    chk("rst_valid", 32'(a.valid), 0);
    chk("rst_bcd", 32'(a.bcd), 0);
    chk("rst_ovf", 32'(a.overflow), 0);
    chk("rst_sign", 32'(a.sign), 0);
    rst = 1'b0;
    step();
    launch_a(18'h3FFFF);
    wait_a();
    repeat (3) step();
    chk("hold_bcd", 32'(a.bcd), 32'(model(18'h3FFFF, 6).bcd));
    launch_a(18'd0);
    wait_a();
    pv = vca;
    launch_a(18'd12345);
    wait_a();
    chk("b2b_gap", 32'(vca - pv), 20);
    launch_a(18'd999);
    n0 = nva;
    while (cyc < tl_a + 3) step();
    a.start = 1'b1;
    a.bin = 18'd5;
    step();
    a.start = 1'b0;
    while (cyc < tl_a + 19) step();
    chk("done_cycle_valid", 32'(a.valid), 1);
    a.start = 1'b1;
    a.bin = 18'd77;
    step();
    a.start = 1'b0;
    repeat (30) step();
    chk("ignored_valid_count", 32'(nva - n0), 1);
    chk("ignored_latency", 32'(vca - tl_a), 19);
    chk("ignored_ready", 32'(a.ready), 1);
    launch_b(18'd12345);
    wait_b();
    launch_b(18'd42);
    wait_b();
    launch_a(18'd100000);
    n0 = nva;
    while (cyc < tl_a + 7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    qa.delete();
    chk("abort_ready", 32'(a.ready), 1);
    chk("abort_valid", 32'(a.valid), 0);
    chk("abort_bcd", 32'(a.bcd), 0);
    chk("abort_ovf", 32'(a.overflow), 0);
    chk("abort_sign", 32'(a.sign), 0);
    repeat (30) step();
    chk("abort_no_valid", 32'(nva - n0), 0);
    launch_a(18'd7);
    wait_a();
    launch_a(18'h20000);
    wait_a();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
